// File: rtl/mem_share_skid_fifo.sv
// ---------------------------------------------------------------------------
// mem_share_skid_fifo
//
// Skid buffer for share-group request flag vectors between the request flag
// generator and the shift-control register file of the memory-share
// scheduler. Vectors move over a valid/ready handshake. Up to SKID_DEPTH
// vectors are held in a circular buffer while the register file applies
// back-pressure. The buffer also supports update masking (freeze), flush,
// and registered occupancy reporting.
//
// Optional feature macro: SKID_BYPASS_EN
//   defined   -> when the buffer is empty and the consumer is ready, the
//                input vector goes straight to the output in the same cycle
//                and is not stored.
//   undefined -> every vector is stored first (minimum latency 1 cycle).
//
// Ports:
//   sys_clk           clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   share_rqstFlag_i  request flags from the generator
//   rqst_valid_i      share_rqstFlag_i valid
//   rqst_ready_o      buffer can accept this cycle
//   share_rqstFlag_o  flags to the register file
//   rqst_valid_o      share_rqstFlag_o valid
//   rqst_ready_i      register file accepts this cycle
//   update_mask_i     freeze: no push, no pop, handshakes forced low
//   flush_i           discard all buffered entries
//   occupancy_o       buffered entry count (registered)
//   full_o            occupancy_o == SKID_DEPTH (registered)
//   empty_o           occupancy_o == 0 (registered)
// ---------------------------------------------------------------------------
module mem_share_skid_fifo #(
  parameter int SHARE_GROUP_SIZE = 5,
  parameter int SKID_DEPTH       = 2,
  parameter int CNT_W            = $clog2(SKID_DEPTH + 1)
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [SHARE_GROUP_SIZE-1:0] share_rqstFlag_i,
  input  logic                        rqst_valid_i,
  output logic                        rqst_ready_o,
  output logic [SHARE_GROUP_SIZE-1:0] share_rqstFlag_o,
  output logic                        rqst_valid_o,
  input  logic                        rqst_ready_i,
  input  logic                        update_mask_i,
  input  logic                        flush_i,
  output logic [CNT_W-1:0]            occupancy_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int              PTR_W   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(SKID_DEPTH - 1);

  logic [SHARE_GROUP_SIZE-1:0] mem_q [SKID_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        full_q, full_d;
  logic                        empty_q, empty_d;

  logic blocked;      // no handshake may complete this cycle
  logic has_data;     // at least one stored entry
  logic bypass_show;  // empty buffer presenting the live input
  logic bypass_take;  // live input consumed directly by the register file
  logic push;
  logic pop;

  // Pointers wrap explicitly so SKID_DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  assign blocked  = rst | flush_i | update_mask_i;
  assign has_data = (count_q != '0);

`ifdef SKID_BYPASS_EN
  assign bypass_show = ~has_data & rqst_valid_i & ~blocked;
`else
  assign bypass_show = 1'b0;
`endif
  assign bypass_take = bypass_show & rqst_ready_i;

  // Ready depends only on local state: no combinational ready pass-through.
  assign rqst_ready_o = ~blocked & (count_q < DEPTH_C);
  assign rqst_valid_o = ~blocked & (has_data | bypass_show);

  assign push = rqst_valid_i & rqst_ready_o & ~bypass_take;
  assign pop  = rqst_valid_o & rqst_ready_i & has_data;

  // Head entry is shown even while masked or flushing; bypass data only when
  // it is actually being offered.
  assign share_rqstFlag_o = rst         ? '0 :
                            has_data    ? mem_q[rd_ptr_q] :
                            bypass_show ? share_rqstFlag_i : '0;

  assign occupancy_o = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;

  // NOTE: every variable is given a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;  // idle, or push and pop together
      endcase
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      // NOTE: the storage array is cleared on reset as well, so the output
      // data is a known zero instead of stale contents after reset.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      if (push) begin
        mem_q[wr_ptr_q] <= share_rqstFlag_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_share_skid_fifo.sv
// ---------------------------------------------------------------------------
// tb_mem_share_skid_fifo
//
// Drives one stimulus stream into two instances of mem_share_skid_fifo
// (SKID_DEPTH = 2 and SKID_DEPTH = 3) and compares each against a queue-based
// reference model every cycle. Inputs are driven on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// Build with +define+SKID_BYPASS_EN to check the bypass configuration.
// ---------------------------------------------------------------------------
module tb_mem_share_skid_fifo;

`ifdef SKID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] flags_i;
  logic       valid_i;
  logic       ready_i;
  logic       mask_i;
  logic       flush_i;

  logic       rdy2, vld2, full2, emp2;
  logic [4:0] dat2;
  logic [1:0] occ2;
  logic       rdy3, vld3, full3, emp3;
  logic [4:0] dat3;
  logic [1:0] occ3;

  int checks = 0;
  int errors = 0;

  logic [4:0] q2[$];
  logic [4:0] q3[$];

  always #5 clk = ~clk;

  mem_share_skid_fifo #(.SHARE_GROUP_SIZE(5), .SKID_DEPTH(2)) dut2 (
    .sys_clk(clk), .rst(rst),
    .share_rqstFlag_i(flags_i), .rqst_valid_i(valid_i), .rqst_ready_o(rdy2),
    .share_rqstFlag_o(dat2), .rqst_valid_o(vld2), .rqst_ready_i(ready_i),
    .update_mask_i(mask_i), .flush_i(flush_i),
    .occupancy_o(occ2), .full_o(full2), .empty_o(emp2)
  );

  mem_share_skid_fifo #(.SHARE_GROUP_SIZE(5), .SKID_DEPTH(3)) dut3 (
    .sys_clk(clk), .rst(rst),
    .share_rqstFlag_i(flags_i), .rqst_valid_i(valid_i), .rqst_ready_o(rdy3),
    .share_rqstFlag_o(dat3), .rqst_valid_o(vld3), .rqst_ready_i(ready_i),
    .update_mask_i(mask_i), .flush_i(flush_i),
    .occupancy_o(occ3), .full_o(full3), .empty_o(emp3)
  );

  // Expected handshake/data outputs of a buffer holding sz entries.
  function automatic void expect_out(
    input  logic       r, v, rdy, m, fl,
    input  logic [4:0] f,
    input  int         sz, d,
    input  logic [4:0] head,
    output logic       e_rdy, e_vld, e_byp,
    output logic [4:0] e_dat
  );
    logic blk;
    blk   = r || m || fl;
    e_rdy = !blk && (sz < d);
    e_byp = BYP && !blk && (sz == 0) && v && rdy;
    e_vld = !blk && ((sz > 0) || (BYP && v));
    if (r)              e_dat = '0;
    else if (sz > 0)    e_dat = head;
    else if (BYP && e_vld) e_dat = f;
    else                e_dat = '0;
  endfunction

  // One clock cycle: drive, check both instances, advance the model.
  task automatic step(input logic r, v, input logic [4:0] f,
                      input logic rdy, m, fl, input bit chk_state,
                      input string tag);
    logic       e_rdy, e_vld, e_byp, a_rdy, a_vld, a_full, a_emp;
    logic [4:0] e_dat, a_dat, head;
    int         sz, d, a_occ;
    @(negedge clk);
    rst = r; valid_i = v; flags_i = f; ready_i = rdy; mask_i = m; flush_i = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      sz   = (k == 0) ? q2.size() : q3.size();
      d    = (k == 0) ? 2 : 3;
      head = (sz == 0) ? 5'h00 : ((k == 0) ? q2[0] : q3[0]);
      expect_out(r, v, rdy, m, fl, f, sz, d, head, e_rdy, e_vld, e_byp, e_dat);
      a_rdy  = (k == 0) ? rdy2  : rdy3;
      a_vld  = (k == 0) ? vld2  : vld3;
      a_dat  = (k == 0) ? dat2  : dat3;
      a_occ  = (k == 0) ? int'(occ2) : int'(occ3);
      a_full = (k == 0) ? full2 : full3;
      a_emp  = (k == 0) ? emp2  : emp3;
      checks++;
      if (a_rdy !== e_rdy) begin
        errors++;
        $display("FAIL %s depth%0d ready: got %b want %b", tag, d, a_rdy, e_rdy);
      end
      checks++;
      if (a_vld !== e_vld) begin
        errors++;
        $display("FAIL %s depth%0d valid: got %b want %b", tag, d, a_vld, e_vld);
      end
      checks++;
      if (a_dat !== e_dat) begin
        errors++;
        $display("FAIL %s depth%0d data: got %h want %h", tag, d, a_dat, e_dat);
      end
      if (chk_state) begin
        checks++;
        if (a_occ !== sz) begin
          errors++;
          $display("FAIL %s depth%0d occupancy: got %0d want %0d", tag, d, a_occ, sz);
        end
        checks++;
        if (a_full !== (sz == d)) begin
          errors++;
          $display("FAIL %s depth%0d full: got %b want %b", tag, d, a_full, sz == d);
        end
        checks++;
        if (a_emp !== (sz == 0)) begin
          errors++;
          $display("FAIL %s depth%0d empty: got %b want %b", tag, d, a_emp, sz == 0);
        end
      end
    end
    // Advance model state for the coming edge.
    if (r || fl) begin
      q2.delete();
      q3.delete();
    end else begin
      expect_out(r, v, rdy, m, fl, f, q2.size(), 2, (q2.size() > 0) ? q2[0] : 5'h00,
                 e_rdy, e_vld, e_byp, e_dat);
      if (e_vld && rdy && q2.size() > 0) void'(q2.pop_front());
      if (v && e_rdy && !e_byp) q2.push_back(f);
      expect_out(r, v, rdy, m, fl, f, q3.size(), 3, (q3.size() > 0) ? q3[0] : 5'h00,
                 e_rdy, e_vld, e_byp, e_dat);
      if (e_vld && rdy && q3.size() > 0) void'(q3.pop_front());
      if (v && e_rdy && !e_byp) q3.push_back(f);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 5'h00, 1, 0, 0, 1, tag);
  endtask

  task automatic test_reset();
    step(1, 1, 5'b10101, 0, 0, 0, 0, "reset");
    step(1, 1, 5'b10101, 0, 0, 0, 1, "reset");
    step(1, 1, 5'b10101, 0, 0, 0, 1, "reset");
    step(0, 0, 5'h00, 0, 0, 0, 1, "reset_release");
  endtask

  task automatic test_streaming();
    step(0, 1, 5'h01, 1, 0, 0, 1, "stream");
    step(0, 1, 5'h02, 1, 0, 0, 1, "stream");
    step(0, 1, 5'h03, 1, 0, 0, 1, "stream");
    idle(2, "stream_drain");
  endtask

  task automatic test_backpressure();
    step(0, 1, 5'h11, 0, 0, 0, 1, "bp_push");
    step(0, 1, 5'h12, 0, 0, 0, 1, "bp_push");
    step(0, 0, 5'h00, 0, 0, 0, 1, "bp_full");
    idle(3, "bp_drain");
  endtask

  task automatic test_mask();
    step(0, 1, 5'h1F, 0, 0, 0, 1, "mask_load");
    for (int i = 0; i < 4; i++) step(0, 0, 5'h00, 1, 1, 0, 1, "mask_hold");
    idle(2, "mask_release");
  endtask

  task automatic test_flush_wrap();
    for (int i = 0; i < 5; i++) step(0, 1, 5'(i + 4), 1, 0, 0, 1, "wrap_pair");
    step(0, 1, 5'h0A, 0, 0, 0, 1, "wrap_fill");
    step(0, 1, 5'h0B, 0, 0, 0, 1, "wrap_fill");
    step(0, 1, 5'h0C, 1, 0, 1, 1, "flush");
    step(0, 0, 5'h00, 0, 0, 0, 1, "post_flush");
    idle(2, "post_flush_idle");
  endtask

  task automatic test_random();
    logic r, v, rdy, m, fl;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(99) < 1);
      v   = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < 60);
      m   = ($urandom_range(99) < 10);
      fl  = ($urandom_range(99) < 5);
      step(r, v, 5'($urandom), rdy, m, fl, 1, "random");
    end
    idle(4, "random_drain");
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; flags_i = '0; ready_i = 1'b0;
    mask_i = 1'b0; flush_i = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_mask();
    test_flush_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_share_skid_fifo.md
# mem_share_skid_fifo

Parametrised successor of the share-group request skid stage. It sits between the request flag generator and the shift-control register file of the memory-share scheduler. It carries SHARE_GROUP_SIZE-wide request flag vectors over a valid/ready handshake, and buffers up to SKID_DEPTH vectors when the register file back-pressures. It adds update masking, flush, occupancy reporting and an optional zero-latency bypass.

## Interface
Parameters:
- SHARE_GROUP_SIZE, 5, width of one request flag vector (requestors per share group), ≥1
- SKID_DEPTH, 2, buffer entries, 2..8
- CNT_W, $clog2(SKID_DEPTH+1), occupancy counter width (derived, do not override)

Ports:
- sys_clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- share_rqstFlag_i  in  SHARE_GROUP_SIZE  request flags from the generator
- rqst_valid_i  in  1  share_rqstFlag_i valid
- rqst_ready_o  out  1  buffer can accept this cycle
- share_rqstFlag_o  out  SHARE_GROUP_SIZE  flags to the register file
- rqst_valid_o  out  1  share_rqstFlag_o valid
- rqst_ready_i  in  1  register file accepts this cycle
- update_mask_i  in  1  freeze; active-high
- flush_i  in  1  discard all buffered entries; active-high
- occupancy_o  out  CNT_W  buffered entry count
- full_o  out  1  occupancy_o == SKID_DEPTH
- empty_o  out  1  occupancy_o == 0

## Operation
- Storage is a circular array of SKID_DEPTH entries with a write pointer, a read pointer and a count. Pointers wrap from SKID_DEPTH-1 to 0; SKID_DEPTH need not be a power of two.
- Push happens when rqst_valid_i && rqst_ready_o && !bypass_take. Pop happens when rqst_valid_o && rqst_ready_i && count>0.
- rqst_ready_o = !rst && !flush_i && !update_mask_i && (count < SKID_DEPTH). It does not depend on rqst_ready_i, so there is no ready pass-through when full.
- rqst_valid_o = !rst && !flush_i && !update_mask_i && (count>0 || bypass_take-eligible input).
- Output data:
  - count>0: head entry.
  - Otherwise, with bypass: share_rqstFlag_i.
  - Otherwise: all zeros.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count < SKID_DEPTH.
- update_mask_i: no push, no pop, pointers, count and storage hold, both handshake outputs are 0. Output data keeps showing the head (or zeros if empty).
- flush_i: takes priority over push, pop and mask. Next cycle count=0 and both pointers=0. Storage contents are don't-care.
- rst: priority over everything. Count and pointers go to 0 and storage clears to 0.

## Timing
- Reset values: rqst_ready_o=0, rqst_valid_o=0, share_rqstFlag_o=0, occupancy_o=0, full_o=0, empty_o=1. From the first cycle after rst deasserts: rqst_ready_o=1 (unless masked or flushing) and empty_o=1.
- Registered path latency: 1 cycle from push to rqst_valid_o.
- Bypass path latency: 0 cycles (combinational).
- Throughput: 1 vector per cycle sustained while rqst_ready_i=1.
- occupancy_o, full_o and empty_o are registered and reflect the count after the previous edge.
- Flush or mask asserted mid-transfer: the handshake in that cycle is suppressed on both sides. The producer must hold its data; the buffer drops nothing except on flush.

## Configuration
- SKID_BYPASS_EN defined: bypass_take = empty && rqst_valid_i && rqst_ready_i && !update_mask_i && !flush_i. The input passes straight to the output with 0-cycle latency and is not stored. When empty, rqst_valid_o follows rqst_valid_i.
- SKID_BYPASS_EN undefined: bypass_take=0. Every vector is stored first; minimum latency is 1 cycle and rqst_valid_o is a function of count only.

## Test plan
- Reset: hold rst 3 cycles with rqst_valid_i=1, flags=5'b10101 -> rqst_valid_o=0, rqst_ready_o=0, share_rqstFlag_o=0, empty_o=1. First cycle after release -> rqst_ready_o=1.
- Streaming, bypass on: rqst_ready_i=1, push 5'h01, 5'h02, 5'h03 on consecutive cycles -> each appears on the same cycle; occupancy_o stays 0.
- Streaming, bypass off: same stimulus -> outputs 5'h01, 5'h02, 5'h03 one cycle later; occupancy_o=1 in steady state.
- Backpressure: rqst_ready_i=0, push 5'h11 then 5'h12 (SKID_DEPTH=2) -> full_o=1 and rqst_ready_o=0 on the next cycle. Raise rqst_ready_i -> 5'h11 then 5'h12 in order, then empty_o=1.
- Mask: with 1 entry (5'h1F) buffered, assert update_mask_i 4 cycles with rqst_ready_i=1 -> rqst_valid_o=0, occupancy_o=1. Deassert -> 5'h1F pops on the next cycle.
- Flush and wrap: SKID_DEPTH=3, do 5 push/pop pairs to wrap the pointers, buffer 2 entries, assert flush_i together with rqst_valid_i -> next cycle occupancy_o=0; the flushed-cycle input is not stored.
